vpg_clken_nco: RTL
==================

// Module: vpg_clken_nco
// PURPOSE
//  Multi-mode pixel-clock-enable generator for the video pattern generator (VPG).
//  A phase-accumulator NCO on refclk makes a one-cycle pixel enable, plus a square-wave
//  pixel phase, for NUM_MODES runtime-selectable video modes. Successor to the fixed
//  single-frequency PLL wrapper: mode switches need no reconfiguration, and lock is reported
//  through a request/ack handshake.
// PARAMETERS
//  ACC_W        32             accumulator width; f_out = f_refclk * inc / 2^ACC_W
//  NUM_MODES    4              number of entries in the mode table (>=1)
//  MODE_W       2              width of mode_sel/cur_mode (>= clog2(NUM_MODES), min 1)
//  MODE_INC     {4{32'd1081250500}}  packed NUM_MODES*ACC_W increment table; entry i = bits [i*ACC_W +: ACC_W]
//                              (default entry: 25.1748 MHz from 100 MHz)
//  DEFAULT_MODE 0              mode loaded at reset
//  LOCK_CYCLES  16             settle cycles before locked asserts (>=1)
// PORTS
//  refclk      in   1          sole clock, rising edge
//  rst         in   1          async reset, ACTIVE-LOW (0 = reset)
//  enable      in   1          1 = NCO runs; 0 = hold
//  mode_req    in   1          mode-change request, sampled each refclk edge
//  mode_sel    in   MODE_W     requested mode, valid with mode_req
//  mode_ack    out  1          one-cycle acknowledge of any sampled mode_req
//  mode_err    out  1          sticky: last request had mode_sel >= NUM_MODES
//  cur_mode    out  MODE_W     mode currently applied
//  pix_ce      out  1          one-cycle pixel clock enable (accumulator carry-out)
//  pix_clk_sq  out  1          accumulator MSB (~50% duty pixel-rate square wave)
//  locked      out  1          1 = output stable at cur_mode rate
// BEHAVIOUR
//  Reset (rst=0, async):
//   - acc=0, inc=MODE_INC[DEFAULT_MODE], cur_mode=DEFAULT_MODE, state=SETTLE, settle_cnt=0.
//   - All outputs 0, except cur_mode = DEFAULT_MODE.
//  States:
//   - SETTLE: acc advances; pix_ce forced 0, pix_clk_sq forced 0; settle_cnt increments.
//     When settle_cnt reaches LOCK_CYCLES-1, go to LOCKED; locked=1 from the next cycle.
//   - LOCKED: {carry, acc} <= acc + inc (ACC_W+1-bit sum; acc wraps mod 2^ACC_W).
//     pix_ce <= carry and pix_clk_sq <= acc[ACC_W-1] are registered, one cycle of latency.
//   - HOLD: entered from any state when enable=0. acc frozen; pix_ce=0, pix_clk_sq=0, locked=0.
//     When enable returns to 1, go to SETTLE with settle_cnt=0; acc is not cleared.
//  Mode request (any state with enable=1; enable=0 has priority and the request is ignored, no ack):
//   - mode_req sampled 1 at edge N -> mode_ack=1 during cycle N+1 only.
//   - Valid mode_sel: inc <= MODE_INC[mode_sel], cur_mode <= mode_sel, acc <= 0, mode_err <= 0,
//     locked <= 0, settle_cnt <= 0, state <= SETTLE. A request made in SETTLE restarts the settle.
//   - Invalid mode_sel (>= NUM_MODES): mode_err <= 1; inc, cur_mode, acc, state and locked unchanged.
//   - mode_req held high: acked every cycle, and each valid request restarts SETTLE.
//  Timing: locked first reads 1 at LOCK_CYCLES+1 cycles after the ack edge, and at
//   LOCK_CYCLES cycles after reset deassertion.
//  Edge cases:
//   - inc=0: pix_ce never asserts; locked still asserts.
//   - inc >= 2^(ACC_W-1): pix_ce may assert on consecutive cycles.
//   - No glitch on locked: it only changes on refclk edges or on async reset.
// TESTING
//  1. ACC_W=8, MODE_INC={8'd128,8'd64,8'd32,8'd16}, LOCK_CYCLES=4. Release rst -> locked=1 at cycle 4;
//     then pix_ce every 16 cycles (mode0 inc=16), pix_clk_sq high 8 and low 8.
//  2. While locked, mode_req=1 with mode_sel=2 for one cycle -> mode_ack one cycle, cur_mode=2,
//     locked=0 for 5 cycles, then pix_ce every 4 cycles.
//  3. mode_req with mode_sel=3, NUM_MODES=3 -> mode_ack=1, mode_err=1; cur_mode, locked and
//     pix_ce cadence unchanged. A following valid request clears mode_err.
//  4. enable=0 for 10 cycles mid-period -> pix_ce=0, locked=0, acc frozen. enable=1 ->
//     locked after 4 cycles; the first pix_ce phase continues from the frozen acc.
//  5. Assert rst=0 asynchronously mid-SETTLE after a mode change -> all outputs 0 at once,
//     cur_mode=DEFAULT_MODE; normal relock after release.
//  6. Defaults (ACC_W=32, inc=1081250500): 10^6 cycles -> 251748 +/- 1 pix_ce pulses.

Source files
------------

// File: rtl/vpg_clken_nco.sv
// vpg_clken_nco -- multi-mode pixel clock-enable NCO for the video pattern generator.
//
// A phase accumulator on refclk produces a one-cycle pixel enable (the accumulator
// carry-out) and a square-wave pixel phase (the accumulator MSB). The rate comes from
// one of NUM_MODES runtime-selectable increments. Mode changes go through a request/ack
// handshake, and locked reports when the output runs steadily at the applied rate.
//
// Ports
//   refclk      in   1       sole clock, rising edge
//   rst         in   1       asynchronous reset, active low
//   enable      in   1       1 = NCO runs, 0 = hold (accumulator frozen)
//   mode_req    in   1       mode-change request, sampled every refclk edge
//   mode_sel    in   MODE_W  requested mode, valid with mode_req
//   mode_ack    out  1       one-cycle acknowledge of each sampled request
//   mode_err    out  1       sticky: last request named a mode outside the table
//   cur_mode    out  MODE_W  mode currently applied
//   pix_ce      out  1       one-cycle pixel clock enable
//   pix_clk_sq  out  1       ~50% duty pixel-rate square wave
//   locked      out  1       output stable at the cur_mode rate
//
// State table
//   state     | meaning
//   ST_SETTLE | accumulator runs, outputs forced low, settle timer counting down
//   ST_LOCKED | accumulator runs, pix_ce / pix_clk_sq driven, locked high
//   ST_HOLD   | enable low: accumulator frozen, all pixel outputs low

module vpg_clken_nco #(
    parameter int                           ACC_W        = 32,
    parameter int                           NUM_MODES    = 4,
    parameter int                           MODE_W       = 2,
    parameter logic [NUM_MODES*ACC_W-1:0]   MODE_INC     = {4{32'd1081250500}},
    parameter int                           DEFAULT_MODE = 0,
    parameter int                           LOCK_CYCLES  = 16
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              enable,
    input  logic              mode_req,
    input  logic [MODE_W-1:0] mode_sel,
    output logic              mode_ack,
    output logic              mode_err,
    output logic [MODE_W-1:0] cur_mode,
    output logic              pix_ce,
    output logic              pix_clk_sq,
    output logic              locked
);

    // Settle timer is a down-counter with a terminal count of zero. After reset or
    // a hold, it starts at LOCK_CYCLES-1 so locked rises LOCK_CYCLES edges later.
    // A mode change loads LOCK_CYCLES, because the request edge itself does not
    // count as a settle cycle; locked then rises LOCK_CYCLES+1 edges after the ack edge.
    localparam int                 CNT_W       = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]   REQ_LOAD    = CNT_W'(LOCK_CYCLES);
    localparam logic [ACC_W-1:0]   RST_INC     = MODE_INC[DEFAULT_MODE*ACC_W +: ACC_W];

    if (NUM_MODES < 1) begin : g_bad_num_modes
        $error("vpg_clken_nco: NUM_MODES must be at least 1");
    end
    if (NUM_MODES > (1 << MODE_W)) begin : g_bad_mode_w
        $error("vpg_clken_nco: MODE_W too narrow for NUM_MODES");
    end
    if (DEFAULT_MODE < 0 || DEFAULT_MODE >= NUM_MODES) begin : g_bad_default
        $error("vpg_clken_nco: DEFAULT_MODE outside the mode table");
    end
    if (LOCK_CYCLES < 1) begin : g_bad_lock
        $error("vpg_clken_nco: LOCK_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_LOCKED = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   inc;
    logic [CNT_W-1:0]   settle_cnt;
    logic [ACC_W:0]     sum;
    logic               sel_valid;
    logic [ACC_W-1:0]   sel_inc;

    // Table lookup by equality so that out-of-table selects never index past MODE_INC.
    always_comb begin
        sel_valid = 1'b0;
        sel_inc   = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (mode_sel == MODE_W'(i)) begin
                sel_valid = 1'b1;
                sel_inc   = MODE_INC[i*ACC_W +: ACC_W];
            end
        end
    end

    assign sum = {1'b0, acc} + {1'b0, inc};

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state      <= ST_SETTLE;
            acc        <= '0;
            inc        <= RST_INC;
            settle_cnt <= SETTLE_LOAD;
            cur_mode   <= MODE_W'(DEFAULT_MODE);
            mode_ack   <= 1'b0;
            mode_err   <= 1'b0;
            pix_ce     <= 1'b0;
            pix_clk_sq <= 1'b0;
            locked     <= 1'b0;
        end else begin
            mode_ack <= 1'b0;
            if (!enable) begin
                // Disable wins over any request; the request is dropped unacknowledged.
                state      <= ST_HOLD;
                pix_ce     <= 1'b0;
                pix_clk_sq <= 1'b0;
                locked     <= 1'b0;
            end else if (mode_req && sel_valid) begin
                mode_ack   <= 1'b1;
                mode_err   <= 1'b0;
                inc        <= sel_inc;
                cur_mode   <= mode_sel;
                acc        <= '0;
                settle_cnt <= REQ_LOAD;
                state      <= ST_SETTLE;
                pix_ce     <= 1'b0;
                pix_clk_sq <= 1'b0;
                locked     <= 1'b0;
            end else begin
                // An invalid request only raises the sticky error; the NCO carries on.
                if (mode_req) begin
                    mode_ack <= 1'b1;
                    mode_err <= 1'b1;
                end
                case (state)
                    ST_SETTLE: begin
                        acc        <= sum[ACC_W-1:0];
                        pix_ce     <= 1'b0;
                        pix_clk_sq <= 1'b0;
                        if (settle_cnt == '0) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end else begin
                            settle_cnt <= settle_cnt - CNT_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        acc        <= sum[ACC_W-1:0];
                        pix_ce     <= sum[ACC_W];
                        pix_clk_sq <= acc[ACC_W-1];
                        locked     <= 1'b1;
                    end
                    default: begin
                        // Leaving hold: the accumulator keeps its frozen phase.
                        state      <= ST_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                        pix_ce     <= 1'b0;
                        pix_clk_sq <= 1'b0;
                        locked     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
